// File: rtl/sample_rebuild_pkg.sv
// Shared definitions for the byte-to-sample rebuild path: pairing states,
// default sizing and the sample width.
package sample_rebuild_pkg;

    typedef enum logic {
        WAIT_MSB = 1'b0,
        WAIT_LSB = 1'b1
    } pair_state_t;

    localparam int SAMPLE_W    = 16;
    localparam int DEPTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock show-ahead FIFO holding rebuilt samples; a push into a full
// buffer only succeeds when the head is popped on the same cycle.
module sample_fifo
    import sample_rebuild_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clk_out1,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              push_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W-1:0] hold_q;
    logic              pop;
    logic              wr_en;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign rd_valid  = !empty;
    assign pop       = pop_ready && !empty;
    assign wr_en     = push && (!full || pop);
    assign push_drop = push && full && !pop;

    // While empty the output repeats the last word handed to the consumer.
    assign rd_data = empty ? hold_q : mem[rd_ptr];

    always_ff @(posedge clk_out1) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_out1) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr];
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_rebuild.sv
// Pairs an MSB-first byte stream into 16-bit samples, abandons a lone MSB
// after TIMEOUT idle cycles and buffers completed samples for the consumer.
module sample_rebuild
    import sample_rebuild_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk_out1,
    input  logic                rst,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                resync
);

    localparam int TW = $clog2(TIMEOUT + 1);

    pair_state_t         state_q;
    pair_state_t         state_nxt;
    logic [7:0]          msb_p0;
    logic [7:0]          msb_nxt;
    logic [TW-1:0]       tmo_cnt;
    logic [TW-1:0]       tmo_cnt_nxt;
    logic                resync_nxt;
    logic                push_vld_p0;
    logic [SAMPLE_W-1:0] word_p0;
    logic                push_drop;
    logic                overflow_q;
    logic                resync_q;

    assign word_p0 = {msb_p0, byte_in};

    // A byte on the cycle the counter sits at TIMEOUT still completes the word.
    always_comb begin
        state_nxt   = state_q;
        msb_nxt     = msb_p0;
        tmo_cnt_nxt = tmo_cnt;
        push_vld_p0 = 1'b0;
        resync_nxt  = 1'b0;
        case (state_q)
            WAIT_MSB: begin
                if (byte_valid) begin
                    msb_nxt     = byte_in;
                    tmo_cnt_nxt = '0;
                    state_nxt   = WAIT_LSB;
                end
            end
            WAIT_LSB: begin
                if (byte_valid) begin
                    push_vld_p0 = 1'b1;
                    state_nxt   = WAIT_MSB;
                end else if (tmo_cnt == TW'(TIMEOUT)) begin
                    msb_nxt     = '0;
                    tmo_cnt_nxt = '0;
                    resync_nxt  = 1'b1;
                    state_nxt   = WAIT_MSB;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            default: state_nxt = WAIT_MSB;
        endcase
    end

    always_ff @(posedge clk_out1) begin
        if (rst) begin
            state_q    <= WAIT_MSB;
            msb_p0     <= '0;
            tmo_cnt    <= '0;
            resync_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            msb_p0   <= msb_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
            resync_q <= resync_nxt;
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign overflow = overflow_q;
    assign resync   = resync_q;

    sample_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (SAMPLE_W)
    ) u_fifo (
        .clk_out1  (clk_out1),
        .rst       (rst),
        .push      (push_vld_p0),
        .push_data (word_p0),
        .pop_ready (sample_ready),
        .rd_data   (sample_out),
        .rd_valid  (sample_valid),
        .full      (full),
        .empty     (empty),
        .push_drop (push_drop)
    );

endmodule
